// File: rtl/shifter_pkg.sv
// ---------------------------------------------------------------------------
// shifter_pkg
// Definitions shared by the shifter family of blocks.
//   norm_state_t         : control state encoding for shift_normalizer
//   NORM_DEFAULT_WIDTH   : default operand width for the normalizer
// ---------------------------------------------------------------------------
package shifter_pkg;

    localparam int NORM_DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_t;

endpackage : shifter_pkg

// File: rtl/shift_normalizer_ctrl.sv
// ---------------------------------------------------------------------------
// shift_normalizer_ctrl
// Control FSM and valid/ready handshake for shift_normalizer.
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   in_valid        : operand offered on the input side
//   out_ready       : consumer accepts the presented result
//   in_is_zero      : offered operand is all zeros
//   in_msb          : offered operand already has its MSB set
//   data_next_msb   : bit WIDTH-2 of the working register (pre-shift)
//   in_ready        : high only in IDLE
//   out_valid       : high only in DONE
//   load            : capture the operand into the datapath this edge
//   shift_en        : shift the datapath register this edge
// ---------------------------------------------------------------------------
module shift_normalizer_ctrl
    import shifter_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic in_valid,
    input  logic out_ready,
    input  logic in_is_zero,
    input  logic in_msb,
    input  logic data_next_msb,
    output logic in_ready,
    output logic out_valid,
    output logic load,
    output logic shift_en
);

    norm_state_t state_reg;
    norm_state_t state_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // in_ready/out_valid depend only on the state register, so no input
    // reaches them combinationally.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        load       = 1'b0;
        shift_en   = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load = 1'b1;
                    // Zero and already-normalized operands need no shifting.
                    if (in_is_zero || in_msb) begin
                        state_next = DONE;
                    end else begin
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                // If bit WIDTH-2 is set, this shift brings a 1 into the MSB.
                if (data_next_msb) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // Returning to IDLE here; in_ready is low on this edge, so no
                // operand is captured at the same time.
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule : shift_normalizer_ctrl

// File: rtl/shift_normalizer.sv
// ---------------------------------------------------------------------------
// shift_normalizer
// Normalizes an operand by shifting it left one bit per clock until its MSB
// is set, reporting the number of leading zeros that were removed.
// Ports:
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   in_valid   : in carries an operand
//   in_ready   : block can accept an operand (IDLE only)
//   in         : operand, WIDTH bits
//   out_valid  : result presented on out/count/zero (DONE only)
//   out_ready  : consumer accepts the result
//   out        : normalized operand, zero-filled from the right
//   count      : leading zeros of the operand (shift applied), SEL bits
//   zero       : operand was all zeros
// ---------------------------------------------------------------------------
module shift_normalizer
    import shifter_pkg::*;
#(
    parameter int WIDTH = NORM_DEFAULT_WIDTH,
    localparam int SEL  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [SEL-1:0]   count,
    output logic             zero
);

    logic [WIDTH-1:0] data_reg;
    logic [SEL-1:0]   count_reg;
    logic             zero_reg;
    logic             load;
    logic             shift_en;
    logic             in_is_zero;

    assign in_is_zero = (in == '0);

    shift_normalizer_ctrl u_ctrl (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .out_ready     (out_ready),
        .in_is_zero    (in_is_zero),
        .in_msb        (in[WIDTH-1]),
        .data_next_msb (data_reg[WIDTH-2]),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .load          (load),
        .shift_en      (shift_en)
    );

    // The controller leaves SHIFT as soon as a 1 reaches the MSB, so count
    // stops at WIDTH-1 (operand = 1) and cannot wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg  <= '0;
            count_reg <= '0;
            zero_reg  <= 1'b0;
        end else if (load) begin
            data_reg  <= in;
            count_reg <= '0;
            zero_reg  <= in_is_zero;
        end else if (shift_en) begin
            data_reg  <= {data_reg[WIDTH-2:0], 1'b0};
            count_reg <= count_reg + SEL'(1);
        end
    end

    assign out   = data_reg;
    assign count = count_reg;
    assign zero  = zero_reg;

endmodule : shift_normalizer
